// File: rtl/dmem_mmio.sv
// dmem_mmio: data-side RAM, UART TX with FIFO, and status/cycle registers.
// Define DMEM_CYCLE_COUNTER_EN to build the free-running CYCLE register.
module dmem_mmio #(
    parameter int          RAM_WORDS    = 1024,
    parameter int          FIFO_DEPTH   = 8,
    parameter int          CLKS_PER_BIT = 868,
    parameter logic [31:0] MMIO_BASE    = 32'h1000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_data_mem_addr,
    input  logic [31:0] i_data_mem_write_data,
    input  logic        i_data_mem_read_en,
    input  logic        i_data_mem_write_en,
    input  logic [1:0]  i_data_mem_data_mask,
    output logic [31:0] o_data_mem_read_data,
    output logic        o_misaligned,
    output logic        o_uart_tx
);

    localparam int IW = $clog2(RAM_WORDS);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

    logic [31:0] addr;
    logic [1:0]  mask;
    logic        access, do_wr, aligned, mis;
    logic        is_ram, is_page, is_mmio;
    logic        ram_we, push_req, stat_wr;
    logic [3:0]  be;
    logic [31:0] wlane, raw, lane, status, cycle_val;
    logic [IW-1:0] ram_idx;

    logic [31:0] ram [RAM_WORDS];
    logic [7:0]  fifo [FIFO_DEPTH];
    logic [AW:0] wptr, rptr;
    logic        full, empty, push, pop, ovf_set, overflow;

    uart_state_t state, state_n;
    logic [BW-1:0] baud, baud_n;
    logic [2:0]    bit_cnt, bit_n;
    logic [7:0]    shreg, sh_n;
    logic          tx;

    assign addr    = i_data_mem_addr;
    assign mask    = i_data_mem_data_mask;
    assign access  = i_data_mem_read_en | i_data_mem_write_en;
    assign do_wr   = i_data_mem_write_en & ~i_data_mem_read_en;
    assign ram_idx = addr[IW+1:2];
    assign is_ram  = (addr[31:IW+2] == '0);
    assign is_page = (addr[31:4] == MMIO_BASE[31:4]);
    // Offset 0xC of the page has no register and behaves as unmapped.
    assign is_mmio = is_page && (addr[3:2] != 2'd3);

    // Alignment rule depends on access size; registers are word-only.
    always_comb begin
        aligned = 1'b1;
        case (mask)
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~addr[0];
            default: aligned = (addr[1:0] == 2'b00);
        endcase
    end

    assign mis = access &
                 ((is_ram & ~aligned) |
                  (is_mmio & (addr[1:0] != 2'b00)));
    assign o_misaligned = mis;

    assign ram_we   = do_wr & is_ram & ~mis;
    assign push_req = do_wr & is_mmio & ~mis & (addr[3:2] == 2'd0);
    assign stat_wr  = do_wr & is_mmio & ~mis & (addr[3:2] == 2'd1);

    // Byte-lane enables and replicated store data for the merge.
    always_comb begin
        be    = 4'hF;
        wlane = i_data_mem_write_data;
        case (mask)
            2'b00: begin
                be    = 4'b0001 << addr[1:0];
                wlane = {4{i_data_mem_write_data[7:0]}};
            end
            2'b01: begin
                be    = addr[1] ? 4'b1100 : 4'b0011;
                wlane = {2{i_data_mem_write_data[15:0]}};
            end
            default: begin
                be    = 4'hF;
                wlane = i_data_mem_write_data;
            end
        endcase
    end

    // Store merges the enabled lanes into the addressed word.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) ram[ram_idx][8*i +: 8] <= wlane[8*i +: 8];
            end
        end
    end

    assign full  = (wptr[AW] != rptr[AW]) &&
                   (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty = (wptr == rptr);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push    = push_req & (~full | pop);
    assign ovf_set = push_req & full & ~pop;

    // FIFO storage; contents are don't-care once pointers are reset.
    always_ff @(posedge clk) begin
        if (push) fifo[wptr[AW-1:0]] <= i_data_mem_write_data[7:0];
    end

    // Pointers and sticky overflow; a new overflow beats a clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            if (ovf_set)      overflow <= 1'b1;
            else if (stat_wr) overflow <= 1'b0;
        end
    end

    // UART state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            baud    <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_n;
            baud    <= baud_n;
            bit_cnt <= bit_n;
            shreg   <= sh_n;
        end
    end

    // UART next-state, FIFO pop and line level.
    always_comb begin
        state_n = state;
        baud_n  = baud;
        bit_n   = bit_cnt;
        sh_n    = shreg;
        pop     = 1'b0;
        tx      = 1'b1;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    sh_n    = fifo[rptr[AW-1:0]];
                    baud_n  = '0;
                    bit_n   = '0;
                    state_n = START;
                end
            end
            START: begin
                tx = 1'b0;
                if (baud == BAUD_LAST) begin
                    baud_n  = '0;
                    state_n = DATA;
                end else begin
                    baud_n = baud + 1'b1;
                end
            end
            DATA: begin
                tx = shreg[0];
                if (baud == BAUD_LAST) begin
                    baud_n = '0;
                    sh_n   = {1'b0, shreg[7:1]};
                    if (bit_cnt == 3'd7) state_n = STOP;
                    else                 bit_n   = bit_cnt + 3'd1;
                end else begin
                    baud_n = baud + 1'b1;
                end
            end
            STOP: begin
                tx = 1'b1;
                if (baud == BAUD_LAST) begin
                    baud_n  = '0;
                    state_n = IDLE;
                end else begin
                    baud_n = baud + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign o_uart_tx = tx;
    assign status = {28'd0, overflow, empty, full, (state != IDLE)};

`ifdef DMEM_CYCLE_COUNTER_EN
    logic [31:0] cycle_cnt;

    // Free-running cycle counter, wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) cycle_cnt <= '0;
        else     cycle_cnt <= cycle_cnt + 32'd1;
    end

    assign cycle_val = cycle_cnt;
`else
    assign cycle_val = '0;
`endif

    // Select the addressed word, then extract the accessed lane.
    always_comb begin
        raw = '0;
        if (is_ram) begin
            raw = ram[ram_idx];
        end else if (is_mmio) begin
            case (addr[3:2])
                2'd1:    raw = status;
                2'd2:    raw = cycle_val;
                default: raw = '0;
            endcase
        end
        case (mask)
            2'b00:   lane = {24'd0, raw[{addr[1:0], 3'b000} +: 8]};
            2'b01:   lane = {16'd0, addr[1] ? raw[31:16] : raw[15:0]};
            default: lane = raw;
        endcase
        o_data_mem_read_data = '0;
        if (i_data_mem_read_en && !mis) o_data_mem_read_data = lane;
    end

endmodule

// File: tb/tb_dmem_mmio.sv
// tb_dmem_mmio: directed bench with read and UART-frame scoreboards.
// Small FIFO and fast baud keep frames short.
module tb_dmem_mmio;

    localparam int          CPB = 4;
    localparam int          FD  = 4;
    localparam logic [31:0] MB  = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr, wdata, rdata;
    logic        read_en, write_en, mis, tx;
    logic [1:0]  mask;

    int total = 0;
    int passed = 0;
    logic [31:0] rd_q[$];
    logic [7:0]  tx_q[$];
    int nframes = 0;
    int naborted = 0;
    int idle_run = 0;
    int gap_log[64];
    int base;
    logic [31:0] c1, c2;
    logic [7:0] t4_bytes[6];

    always #5 clk = ~clk;

    dmem_mmio #(
        .RAM_WORDS(1024),
        .FIFO_DEPTH(FD),
        .CLKS_PER_BIT(CPB),
        .MMIO_BASE(MB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .i_data_mem_addr(addr),
        .i_data_mem_write_data(wdata),
        .i_data_mem_read_en(read_en),
        .i_data_mem_write_en(write_en),
        .i_data_mem_data_mask(mask),
        .o_data_mem_read_data(rdata),
        .o_misaligned(mis),
        .o_uart_tx(tx)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] m, input logic em);
        @(negedge clk);
        read_en = 1'b0; write_en = 1'b1;
        addr = a; wdata = d; mask = m;
        #1 chk($sformatf("wr_mis@%h", a), {31'd0, mis}, {31'd0, em});
    endtask

    task automatic rd(input string tag, input logic [31:0] a,
                      input logic [1:0] m, input logic [31:0] exp,
                      input logic em);
        rd_q.push_back(exp);
        @(negedge clk);
        write_en = 1'b0; read_en = 1'b1;
        addr = a; mask = m;
        #1;
        chk(tag, rdata, rd_q.pop_front());
        chk({tag, "_mis"}, {31'd0, mis}, {31'd0, em});
    endtask

    task automatic peek(input logic [31:0] a, output logic [31:0] v);
        @(negedge clk);
        write_en = 1'b0; read_en = 1'b1;
        addr = a; mask = 2'b10;
        #1 v = rdata;
    endtask

    task automatic idle();
        @(negedge clk);
        read_en = 1'b0; write_en = 1'b0;
    endtask

    task automatic wait_frames(input int target, input int lim,
                               input string tag);
        int cyc = 0;
        while (nframes < target && cyc < lim) begin
            @(negedge clk);
            cyc++;
        end
        chk(tag, 32'(nframes), 32'(target));
    endtask

    // Serial decoder: checks every sample of each bit against the
    // expected byte popped at the start bit.
    initial begin
        logic [7:0]     exp_b, got;
        logic [CPB-1:0] samp;
        logic           eb, aborted;
        forever begin
            @(negedge clk);
            if (rst !== 1'b0) begin
                idle_run = 0;
                continue;
            end
            if (tx !== 1'b0) begin
                idle_run++;
                continue;
            end
            if (nframes < 64) gap_log[nframes] = idle_run;
            total++;
            assert (tx_q.size() != 0) passed++;
            else $error("FAIL frame_expected: observed no queued byte expected one");
            exp_b = (tx_q.size() != 0) ? tx_q.pop_front() : 8'h00;
            got = '0;
            aborted = 1'b0;
            for (int b = 0; b < 10; b++) begin
                eb = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : exp_b[b-1];
                samp = '0;
                for (int s = 0; s < CPB; s++) begin
                    if (!(b == 0 && s == 0)) begin
                        @(negedge clk);
                        if (rst !== 1'b0) begin
                            aborted = 1'b1;
                            break;
                        end
                    end
                    samp[s] = tx;
                end
                if (aborted) break;
                chk($sformatf("uart_bit%0d", b), 32'(samp), 32'({CPB{eb}}));
                if (b >= 1 && b <= 8) got[b-1] = samp[CPB/2];
            end
            if (aborted) begin
                naborted++;
            end else begin
                chk("uart_byte", {24'd0, got}, {24'd0, exp_b});
                nframes++;
            end
            idle_run = 0;
        end
    end

    initial begin
        t4_bytes = '{8'hA5, 8'h3C, 8'h01, 8'h80, 8'hFE, 8'h77};
        rst = 1'b1;
        read_en = 1'b0; write_en = 1'b0;
        addr = '0; wdata = '0; mask = 2'b00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1 chk("reset_tx", {31'd0, tx}, 32'd1);
        rd("reset_status", MB + 32'h4, 2'b10, 32'h4, 1'b0);
        rd("status_byte", MB + 32'h4, 2'b00, 32'h4, 1'b0);

        wr(32'h10, 32'h1122_3344, 2'b10, 1'b0);
        wr(32'h12, 32'h0000_00AB, 2'b00, 1'b0);
        rd("t1_word", 32'h10, 2'b10, 32'h11AB_3344, 1'b0);
        rd("t1_half", 32'h12, 2'b01, 32'h0000_11AB, 1'b0);
        rd("t1_byte", 32'h13, 2'b00, 32'h0000_0011, 1'b0);
        rd("t1_byte0", 32'h10, 2'b00, 32'h0000_0044, 1'b0);

        wr(32'h30, 32'hDEAD_BEEF, 2'b11, 1'b0);
        rd("mask11", 32'h30, 2'b11, 32'hDEAD_BEEF, 1'b0);
        @(negedge clk);
        read_en = 1'b1; write_en = 1'b1;
        addr = 32'h30; wdata = 32'h0; mask = 2'b10;
        rd("rw_both", 32'h30, 2'b10, 32'hDEAD_BEEF, 1'b0);

        wr(32'h20, 32'hCAFE_F00D, 2'b10, 1'b0);
        wr(32'h21, 32'h0000_BEEF, 2'b01, 1'b1);
        rd("t2_ram_kept", 32'h20, 2'b10, 32'hCAFE_F00D, 1'b0);
        rd("t2_mis_word", 32'h22, 2'b10, 32'h0, 1'b1);
        rd("t2_half_ok", 32'h22, 2'b01, 32'h0000_CAFE, 1'b0);
        rd("mmio_mis", MB + 32'h5, 2'b10, 32'h0, 1'b1);
        rd("txdata_rd", MB, 2'b10, 32'h0, 1'b0);

        tx_q.push_back(8'h55);
        wr(MB, 32'h55, 2'b10, 1'b0);
        idle();
        rd("t3_busy", MB + 32'h4, 2'b10, 32'h5, 1'b0);
        wait_frames(1, 100, "t3_frame");
        rd("t3_idle", MB + 32'h4, 2'b10, 32'h4, 1'b0);

        base = nframes;
        for (int i = 0; i < 6; i++) begin
            if (i < 5) tx_q.push_back(t4_bytes[i]);
            wr(MB, {24'd0, t4_bytes[i]}, 2'b10, 1'b0);
        end
        idle();
        rd("t4_ovf", MB + 32'h4, 2'b10, 32'hB, 1'b0);
        wr(MB + 32'h4, 32'hFFFF_FFFF, 2'b10, 1'b0);
        rd("t4_clr", MB + 32'h4, 2'b10, 32'h3, 1'b0);
        wait_frames(base + 5, 600, "t4_frames");
        for (int k = 1; k < 5; k++)
            chk($sformatf("t4_gap%0d", k), 32'(gap_log[base+k]), 32'd1);
        chk("t4_q_empty", 32'(tx_q.size()), 32'd0);
        rd("t4_idle", MB + 32'h4, 2'b10, 32'h4, 1'b0);

        base = nframes;
        tx_q.push_back(8'hC3);
        wr(MB, 32'hC3, 2'b10, 1'b0);
        wr(MB, 32'h99, 2'b10, 1'b0);
        idle();
        repeat (17) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1 chk("t5_tx_high", {31'd0, tx}, 32'd1);
        rst = 1'b0;
        rd("t5_status", MB + 32'h4, 2'b10, 32'h4, 1'b0);
        repeat (100) @(negedge clk);
        chk("t5_no_frames", 32'(nframes), 32'(base));
        chk("t5_aborted", 32'(naborted), 32'd1);
        chk("t5_q_empty", 32'(tx_q.size()), 32'd0);

        rd("unmapped", 32'h0800_0000, 2'b10, 32'h0, 1'b0);
        rd("unmapped_odd", 32'h0800_0002, 2'b10, 32'h0, 1'b0);
`ifdef DMEM_CYCLE_COUNTER_EN
        peek(MB + 32'h8, c1);
        repeat (9) @(negedge clk);
        peek(MB + 32'h8, c2);
        chk("cycle_delta", c2 - c1, 32'd10);
`else
        c1 = '0;
        c2 = '0;
        rd("cycle_absent", MB + 32'h8, 2'b10, 32'h0, 1'b0);
`endif
        idle();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
